// File: rtl/img_pkg.sv
// Shared types and constants for the image stream stages.
// Decimation encoding, default frame size, marker bundle.
package img_pkg;

  localparam int DEF_COLS = 1024;
  localparam int DEF_ROWS = 768;

  localparam logic [1:0] DEC_1 = 2'd0;
  localparam logic [1:0] DEC_2 = 2'd1;
  localparam logic [1:0] DEC_4 = 2'd2;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } marker_t;

  function automatic logic [1:0] dec_mask(
    input logic [1:0] dec
  );
    logic [1:0] m;
    m = 2'b00;
    unique case (1'b1)
      (dec == DEC_1): m = 2'b00;
      (dec == DEC_2): m = 2'b01;
      (dec == DEC_4): m = 2'b11;
      default:        m = 2'b00;
    endcase
    return m;
  endfunction

  function automatic logic dec_ok(
    input logic [1:0] dec
  );
    return dec != 2'd3;
  endfunction

endpackage

// File: rtl/image_crop_if.sv
// Pixel stream in/out bundle for image_crop.
// slave: the crop stage; master: its environment.
interface image_crop_if #(
  parameter int DATA_W = 16
);

  logic                     pi_data_valid;
  logic                     pi_sof;
  logic signed [DATA_W-1:0] pi_data;

  logic                     po_data_valid;
  logic signed [DATA_W-1:0] po_data;
  logic                     po_sof;
  logic                     po_eol;
  logic                     po_eof;
  logic                     po_cfg_err;
  logic                     po_trunc;

  modport slave (
    input  pi_data_valid,
    input  pi_sof,
    input  pi_data,
    output po_data_valid,
    output po_data,
    output po_sof,
    output po_eol,
    output po_eof,
    output po_cfg_err,
    output po_trunc
  );

  modport master (
    output pi_data_valid,
    output pi_sof,
    output pi_data,
    input  po_data_valid,
    input  po_data,
    input  po_sof,
    input  po_eol,
    input  po_eof,
    input  po_cfg_err,
    input  po_trunc
  );

endinterface

// File: rtl/img_pos_cnt.sv
// Raster position tracker: col/row of the current beat,
// frame-start and mid-frame sof (truncation) flags.
module img_pos_cnt #(
  parameter int COLS  = 1024,
  parameter int ROWS  = 768,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             beat,
  input  logic             sof,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             frame_start,
  output logic             trunc
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  // Position the next beat will occupy unless it carries sof.
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;
  logic             at_origin;

  assign at_origin   = (nxt_col == '0) && (nxt_row == '0);
  assign col         = sof ? '0 : nxt_col;
  assign row         = sof ? '0 : nxt_row;
  assign frame_start = beat && (col == '0) && (row == '0);
  assign trunc       = beat && sof && !at_origin;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      nxt_col <= '0;
      nxt_row <= '0;
    end else if (beat) begin
      if (col == COL_LAST) begin
        nxt_col <= '0;
        nxt_row <= (row == ROW_LAST) ? '0
                 : row + ROW_W'(1);
      end else begin
        nxt_col <= col + COL_W'(1);
        nxt_row <= row;
      end
    end
  end

endmodule

// File: rtl/image_crop.sv
// Runtime window crop with 1/2/4 decimation on a pixel stream.
// Config is shadowed at each frame start; 1-cycle latency.
module image_crop
  import img_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAME_COLS = DEF_COLS,
  parameter int FRAME_ROWS = DEF_ROWS,
  parameter int COL_W      = $clog2(FRAME_COLS),
  parameter int ROW_W      = $clog2(FRAME_ROWS)
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic [COL_W-1:0] cfg_x0,
  input  logic [ROW_W-1:0] cfg_y0,
  input  logic [COL_W:0]   cfg_w,
  input  logic [ROW_W:0]   cfg_h,
  input  logic [1:0]       cfg_dec,
  image_crop_if.slave      bus
);

  localparam logic [COL_W:0] COLS_L = (COL_W+1)'(FRAME_COLS);
  localparam logic [ROW_W:0] ROWS_L = (ROW_W+1)'(FRAME_ROWS);
  localparam logic [COL_W:0] W_ONE  = (COL_W+1)'(1);
  localparam logic [ROW_W:0] H_ONE  = (ROW_W+1)'(1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             frame_start;
  logic             trunc;

  img_pos_cnt #(
    .COLS  (FRAME_COLS),
    .ROWS  (FRAME_ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .beat        (bus.pi_data_valid),
    .sof         (bus.pi_sof),
    .col         (col),
    .row         (row),
    .frame_start (frame_start),
    .trunc       (trunc)
  );

  // Live config evaluation, used only on the frame-start beat.
  logic [1:0]       live_mask;
  logic [COL_W:0]   x_end;
  logic [ROW_W:0]   y_end;
  logic [COL_W:0]   w_span;
  logic [ROW_W:0]   h_span;
  logic [COL_W-1:0] live_xl;
  logic [ROW_W-1:0] live_yl;
  logic             live_ok;

  assign live_mask = dec_mask(cfg_dec);
  assign x_end     = {1'b0, cfg_x0} + cfg_w;
  assign y_end     = {1'b0, cfg_y0} + cfg_h;
  assign w_span    = (cfg_w - W_ONE)
                   & ~((COL_W+1)'(live_mask));
  assign h_span    = (cfg_h - H_ONE)
                   & ~((ROW_W+1)'(live_mask));
  assign live_xl   = COL_W'({1'b0, cfg_x0} + w_span);
  assign live_yl   = ROW_W'({1'b0, cfg_y0} + h_span);
  assign live_ok   = (cfg_w != '0) && (cfg_h != '0)
                  && (x_end <= COLS_L)
                  && (y_end <= ROWS_L)
                  && dec_ok(cfg_dec);

  logic [COL_W-1:0] sh_x0;
  logic [ROW_W-1:0] sh_y0;
  logic [COL_W-1:0] sh_xl;
  logic [ROW_W-1:0] sh_yl;
  logic [1:0]       sh_mask;
  logic             sh_ok;

  logic [COL_W-1:0] cur_x0;
  logic [ROW_W-1:0] cur_y0;
  logic [COL_W-1:0] cur_xl;
  logic [ROW_W-1:0] cur_yl;
  logic [1:0]       cur_mask;
  logic             cur_ok;

  assign cur_x0   = frame_start ? cfg_x0    : sh_x0;
  assign cur_y0   = frame_start ? cfg_y0    : sh_y0;
  assign cur_xl   = frame_start ? live_xl   : sh_xl;
  assign cur_yl   = frame_start ? live_yl   : sh_yl;
  assign cur_mask = frame_start ? live_mask : sh_mask;
  assign cur_ok   = frame_start ? live_ok   : sh_ok;

  // Inside the window and on the decimation grid.
  logic [COL_W-1:0] dx;
  logic [ROW_W-1:0] dy;
  logic             in_x;
  logic             in_y;
  logic             keep;
  marker_t          mk;

  assign dx   = col - cur_x0;
  assign dy   = row - cur_y0;
  assign in_x = (col >= cur_x0) && (col <= cur_xl)
             && ((dx & COL_W'(cur_mask)) == '0);
  assign in_y = (row >= cur_y0) && (row <= cur_yl)
             && ((dy & ROW_W'(cur_mask)) == '0);
  assign keep = bus.pi_data_valid && cur_ok
             && in_x && in_y;

  always_comb begin
    mk     = '0;
    mk.sof = (col == cur_x0) && (row == cur_y0);
    mk.eol = (col == cur_xl);
    mk.eof = (col == cur_xl) && (row == cur_yl);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_x0   <= '0;
      sh_y0   <= '0;
      sh_xl   <= '0;
      sh_yl   <= '0;
      sh_mask <= '0;
      sh_ok   <= 1'b0;
    end else if (frame_start) begin
      sh_x0   <= cfg_x0;
      sh_y0   <= cfg_y0;
      sh_xl   <= live_xl;
      sh_yl   <= live_yl;
      sh_mask <= live_mask;
      sh_ok   <= live_ok;
    end
  end

  marker_t mk_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.po_data_valid <= 1'b0;
      bus.po_data       <= '0;
      mk_q              <= '0;
      bus.po_trunc      <= 1'b0;
      bus.po_cfg_err    <= 1'b1;
    end else begin
      bus.po_data_valid <= keep;
      mk_q              <= keep ? mk : '0;
      bus.po_trunc      <= trunc;
      if (keep) begin
        bus.po_data <= bus.pi_data;
      end
      if (frame_start) begin
        bus.po_cfg_err <= !live_ok;
      end
    end
  end

  assign bus.po_sof = mk_q.sof;
  assign bus.po_eol = mk_q.eol;
  assign bus.po_eof = mk_q.eof;

endmodule

// File: tb/tb_image_crop.sv
// Directed bench for image_crop on an 8x6 frame with a
// per-cycle reference model and literal scenario results.
module tb_image_crop;

  localparam int COLS = 8;
  localparam int ROWS = 6;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] cfg_x0;
  logic [2:0] cfg_y0;
  logic [3:0] cfg_w;
  logic [3:0] cfg_h;
  logic [1:0] cfg_dec;

  image_crop_if #(.DATA_W(16)) bus ();

  image_crop #(
    .DATA_W     (16),
    .FRAME_COLS (COLS),
    .FRAME_ROWS (ROWS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_x0    (cfg_x0),
    .cfg_y0    (cfg_y0),
    .cfg_w     (cfg_w),
    .cfg_h     (cfg_h),
    .cfg_dec   (cfg_dec),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference model: expected outputs one cycle after a beat.
  int mcol, mrow;
  int sx0, sy0, sw, sh, ss;
  bit sok;
  bit e_valid, e_sof, e_eol, e_eof, e_trunc, e_err;
  int e_data;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mcol = 0; mrow = 0;
      sx0 = 0; sy0 = 0; sw = 0; sh = 0; ss = 1;
      sok = 0;
      e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0;
      e_trunc = 0; e_err = 1; e_data = 0;
    end else begin
      int x, y;
      e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0;
      e_trunc = 0;
      if (bus.pi_data_valid) begin
        x = mcol; y = mrow;
        if (bus.pi_sof) begin
          if (x != 0 || y != 0) e_trunc = 1;
          x = 0; y = 0;
        end
        if (x == 0 && y == 0) begin
          sx0 = int'(cfg_x0); sy0 = int'(cfg_y0);
          sw = int'(cfg_w); sh = int'(cfg_h);
          ss = 1 << int'(cfg_dec);
          sok = sw != 0 && sh != 0 && sx0 + sw <= COLS
             && sy0 + sh <= ROWS && cfg_dec != 2'd3;
          e_err = !sok;
        end
        if (sok && x >= sx0 && x < sx0 + sw
            && y >= sy0 && y < sy0 + sh
            && (x - sx0) % ss == 0
            && (y - sy0) % ss == 0) begin
          e_valid = 1;
          e_data = int'(bus.pi_data);
          e_sof = (x == sx0) && (y == sy0);
          e_eol = (x + ss >= sx0 + sw);
          e_eof = e_eol && (y + ss >= sy0 + sh);
        end
        x++;
        if (x == COLS) begin
          x = 0; y++;
          if (y == ROWS) y = 0;
        end
        mcol = x; mrow = y;
      end
    end
  end

  bit run_chk = 0;
  int got_q[$];
  int n_sof, n_eol, n_eof, n_trunc;

  always @(negedge sys_clk) begin
    if (sys_rst_n && run_chk) begin
      chk("valid", int'(bus.po_data_valid), int'(e_valid));
      chk("data", int'(bus.po_data), e_data);
      chk("sof", int'(bus.po_sof), int'(e_sof));
      chk("eol", int'(bus.po_eol), int'(e_eol));
      chk("eof", int'(bus.po_eof), int'(e_eof));
      chk("trunc", int'(bus.po_trunc), int'(e_trunc));
      chk("cfg_err", int'(bus.po_cfg_err), int'(e_err));
      if (bus.po_data_valid) begin
        got_q.push_back(int'(bus.po_data));
        if (bus.po_sof) n_sof++;
        if (bus.po_eol) n_eol++;
        if (bus.po_eof) n_eof++;
      end
      if (bus.po_trunc) n_trunc++;
    end
  end

  task automatic clear();
    got_q.delete();
    n_sof = 0; n_eol = 0; n_eof = 0; n_trunc = 0;
  endtask

  task automatic set_cfg(input int x0, input int y0,
                         input int w, input int h,
                         input int dec);
    cfg_x0 = 3'(x0); cfg_y0 = 3'(y0);
    cfg_w = 4'(w); cfg_h = 4'(h);
    cfg_dec = 2'(dec);
  endtask

  task automatic beat(input int d, input bit s);
    @(negedge sys_clk);
    bus.pi_data_valid = 1'b1;
    bus.pi_sof = s;
    bus.pi_data = 16'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      bus.pi_data_valid = 1'b0;
      bus.pi_sof = 1'b0;
    end
  endtask

  task automatic frame(input int n, input bit gap,
                       input int sof_at);
    for (int i = 0; i < n; i++) begin
      beat(i, i == sof_at);
      if (gap) idle(1);
    end
    idle(3);
  endtask

  task automatic expect_list(input string nm,
                             input int exp[$]);
    chk({nm, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_px%0d", nm, i), got_q[i], exp[i]);
    end
  endtask

  task automatic marks(input string nm, input int s,
                       input int l, input int f,
                       input int t);
    chk({nm, "_nsof"}, n_sof, s);
    chk({nm, "_neol"}, n_eol, l);
    chk({nm, "_neof"}, n_eof, f);
    chk({nm, "_ntrunc"}, n_trunc, t);
  endtask

  initial begin
    int exp_q[$];
    bus.pi_data_valid = 1'b0;
    bus.pi_sof = 1'b0;
    bus.pi_data = '0;
    set_cfg(0, 0, 0, 0, 0);
    clear();
    repeat (2) @(negedge sys_clk);
    #1;
    chk("rst_valid", int'(bus.po_data_valid), 0);
    chk("rst_data", int'(bus.po_data), 0);
    chk("rst_marks", int'({bus.po_sof, bus.po_eol,
                           bus.po_eof}), 0);
    chk("rst_trunc", int'(bus.po_trunc), 0);
    chk("rst_cfg_err", int'(bus.po_cfg_err), 1);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    run_chk = 1;

    // Plain crop
    set_cfg(2, 1, 3, 2, 0);
    clear();
    frame(48, 0, -1);
    exp_q = '{10, 11, 12, 18, 19, 20};
    expect_list("crop", exp_q);
    marks("crop", 1, 2, 1, 0);
    chk("crop_err", int'(bus.po_cfg_err), 0);

    // Decimate by 4
    set_cfg(0, 0, 8, 6, 2);
    clear();
    frame(48, 0, -1);
    exp_q = '{0, 4, 32, 36};
    expect_list("dec4", exp_q);
    marks("dec4", 1, 2, 1, 0);

    // Invalid config, fixed mid-frame, then next frame
    set_cfg(6, 0, 3, 2, 0);
    clear();
    for (int i = 0; i < 48; i++) begin
      beat(i, 1'b0);
      if (i == 10) set_cfg(2, 1, 3, 2, 0);
    end
    idle(3);
    chk("inv_count", got_q.size(), 0);
    chk("inv_err", int'(bus.po_cfg_err), 1);
    clear();
    frame(48, 0, -1);
    exp_q = '{10, 11, 12, 18, 19, 20};
    expect_list("recov", exp_q);
    chk("recov_err", int'(bus.po_cfg_err), 0);

    // Mid-frame sof at beat 20
    set_cfg(0, 0, 2, 4, 0);
    clear();
    frame(68, 0, 20);
    exp_q = '{0, 1, 8, 9, 16, 17, 20, 21,
              28, 29, 36, 37, 44, 45};
    expect_list("trunc", exp_q);
    marks("trunc", 2, 7, 1, 1);

    // Gapped input, same crop
    set_cfg(2, 1, 3, 2, 0);
    clear();
    frame(48, 1, -1);
    exp_q = '{10, 11, 12, 18, 19, 20};
    expect_list("gap", exp_q);
    marks("gap", 1, 2, 1, 0);

    // Reset mid-frame, then 1x1 window at (7,5)
    set_cfg(7, 5, 1, 1, 0);
    for (int i = 0; i < 20; i++) beat(i, 1'b0);
    @(negedge sys_clk);
    bus.pi_data_valid = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mrst_err", int'(bus.po_cfg_err), 1);
    chk("mrst_data", int'(bus.po_data), 0);
    #1 sys_rst_n = 1'b1;
    clear();
    frame(48, 0, -1);
    exp_q = '{47};
    expect_list("one", exp_q);
    marks("one", 1, 1, 1, 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
